// File: rtl/tl_cntr_multi_pkg.sv
// Shared phase encodings, lamp codes and small decode helpers for the
// multi-direction traffic-light controller.
package tl_cntr_multi_pkg;

    typedef enum logic [1:0] {
        PH_STR_G  = 2'b00,
        PH_STR_Y  = 2'b01,
        PH_LEFT_G = 2'b10,
        PH_LEFT_Y = 2'b11
    } phase_t;

    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_YEL = 2'b01;
    localparam logic [1:0] LT_GRN = 2'b10;

    function automatic logic is_green(input phase_t ph);
        return (ph == PH_STR_G) || (ph == PH_LEFT_G);
    endfunction

    function automatic logic is_left(input phase_t ph);
        return (ph == PH_LEFT_G) || (ph == PH_LEFT_Y);
    endfunction

    // Code driven onto the single active lamp of the served direction.
    function automatic logic [1:0] lamp_code(input phase_t ph);
        return is_green(ph) ? LT_GRN : LT_YEL;
    endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Dwell timer for the traffic-light controller: counts cycles spent in the
// current phase and flags the minimum-green, maximum-green and yellow limits.
module tl_dwell_timer
    import tl_cntr_multi_pkg::*;
#(
    parameter int YEL_CYC     = 3,
    parameter int MIN_GRN_CYC = 5,
    parameter int MAX_GRN_CYC = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic min_done,
    output logic max_done,
    output logic yel_done
);

    localparam int TW = $clog2(MAX_GRN_CYC) + 1;

    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GRN_CYC - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GRN_CYC - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YEL_CYC - 1);

    logic [TW-1:0] tmr;

    // Holding at the maximum keeps the counter from wrapping; the controller
    // always leaves a phase no later than that point anyway.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tmr <= '0;
        end else if (tmr != MAX_LAST) begin
            tmr <= tmr + 1'b1;
        end
    end

    assign min_done = (tmr >= MIN_LAST);
    assign max_done = (tmr == MAX_LAST);
    assign yel_done = (tmr == YEL_LAST);

endmodule

// File: rtl/tl_cntr_multi.sv
// Round-robin traffic-light controller with straight and protected-left phases.
// Define TL_LEFT_SKIP_EN to skip a direction's left phases when no left car waits.
module tl_cntr_multi
    import tl_cntr_multi_pkg::*;
#(
    parameter int N_DIR       = 2,
    parameter int YEL_CYC     = 3,
    parameter int MIN_GRN_CYC = 5,
    parameter int MAX_GRN_CYC = 30,
    localparam int DW         = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_DIR-1:0]   t_str,
    input  logic [N_DIR-1:0]   t_left,
    output logic [2*N_DIR-1:0] lt_str,
    output logic [2*N_DIR-1:0] lt_left,
    output logic [DW-1:0]      dir,
    output logic [1:0]         phase
);

    localparam logic [DW-1:0] LAST_DIR = DW'(N_DIR - 1);

    phase_t        ph_q;
    phase_t        ph_n;
    logic [DW-1:0] dir_n;
    logic [DW-1:0] dir_inc;
    logic          change;
    logic          sensor;
    logic          green_exit;
    logic          min_done;
    logic          max_done;
    logic          yel_done;

    tl_dwell_timer #(
        .YEL_CYC     (YEL_CYC),
        .MIN_GRN_CYC (MIN_GRN_CYC),
        .MAX_GRN_CYC (MAX_GRN_CYC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (change),
        .min_done (min_done),
        .max_done (max_done),
        .yel_done (yel_done)
    );

    // Explicit wrap keeps non-power-of-two direction counts in range.
    assign dir_inc    = (dir == LAST_DIR) ? '0 : dir + 1'b1;
    assign sensor     = (ph_q == PH_LEFT_G) ? t_left[dir] : t_str[dir];
    assign green_exit = max_done || (min_done && !sensor);

    always_comb begin
        ph_n   = ph_q;
        dir_n  = dir;
        change = 1'b0;
        unique case (ph_q)
            PH_STR_G: begin
                if (green_exit) begin
                    ph_n   = PH_STR_Y;
                    change = 1'b1;
                end
            end
            PH_STR_Y: begin
                if (yel_done) begin
                    change = 1'b1;
`ifdef TL_LEFT_SKIP_EN
                    if (!t_left[dir]) begin
                        ph_n  = PH_STR_G;
                        dir_n = dir_inc;
                    end else begin
                        ph_n  = PH_LEFT_G;
                    end
`else
                    ph_n   = PH_LEFT_G;
`endif
                end
            end
            PH_LEFT_G: begin
                if (green_exit) begin
                    ph_n   = PH_LEFT_Y;
                    change = 1'b1;
                end
            end
            PH_LEFT_Y: begin
                if (yel_done) begin
                    ph_n   = PH_STR_G;
                    dir_n  = dir_inc;
                    change = 1'b1;
                end
            end
            default: begin
                ph_n   = PH_STR_G;
                change = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir  <= '0;
            ph_q <= PH_STR_G;
        end else begin
            dir  <= dir_n;
            ph_q <= ph_n;
        end
    end

    assign phase = ph_q;

    // Only the served direction's active lamp is ever lit; everything else red.
    always_comb begin
        lt_str  = {N_DIR{LT_RED}};
        lt_left = {N_DIR{LT_RED}};
        if (is_left(ph_q)) begin
            lt_left[2*int'(dir) +: 2] = lamp_code(ph_q);
        end else begin
            lt_str[2*int'(dir) +: 2]  = lamp_code(ph_q);
        end
    end

endmodule
